// File: rtl/ret_stack_pkg.sv
// Shared constants and helpers for the return-address stack.
// The CPU top uses RS_WIDTH/RS_DEPTH so the PC width and stack width agree.
package ret_stack_pkg;

    localparam int RS_WIDTH = 10;
    localparam int RS_DEPTH = 8;

    // Width needed to hold an occupancy value from 0 to depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ret_stack_mem.sv
// Purpose: DEPTH x WIDTH storage, synchronous write port, asynchronous read port.
// Latency: write visible on rd_dat after the rising edge; read is combinational.
// Backpressure: none, every wr_en cycle commits one write.
module ret_stack_mem #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_dat
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    // Contents are deliberately not reset; they are ignored while the stack is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/ret_stack.sv
// Purpose: return-address stack (push on CALL, pop on RET); optional wrap mode via RET_STACK_WRAP_EN.
// Latency: push visible on dout after 1 edge; top of stack is read combinationally for same-cycle RET.
// Backpressure: none; push when full is dropped (or overwrites oldest in wrap mode), pop when empty is ignored.
module ret_stack
    import ret_stack_pkg::*;
#(
    parameter int WIDTH = RS_WIDTH,
    parameter int DEPTH = RS_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          dout,
    output logic                      empty,
    output logic                      full,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

`ifdef RET_STACK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic [PW-1:0]    sp;
    logic [PW-1:0]    top_idx;
    logic [WIDTH-1:0] rd_dat;

    logic replace;
    logic push_ok;
    logic pop_ok;
    logic ovf_hit;
    logic udf_hit;
    logic wr_en;
    logic [PW-1:0] wr_addr;

    assign top_idx = sp - PW'(1);
    assign empty   = (count == CW'(0));
    assign full    = (count == CW'(DEPTH));

    // Push+pop on a non-empty stack rewrites the top in place; on an empty
    // stack the pop is discarded and the cycle behaves as a plain push.
    assign replace = push && pop && !empty;
    assign push_ok = push && !replace && (!full || WRAP);
    assign pop_ok  = pop && !push && !empty;
    assign ovf_hit = push && !replace && full;
    assign udf_hit = pop && !push && empty;

    assign wr_en   = replace || push_ok;
    assign wr_addr = replace ? top_idx : sp;

    always_ff @(posedge clk) begin
        if (reset) begin
            sp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                sp <= sp + PW'(1);
                if (!full) begin
                    count <= count + CW'(1);
                end
            end else if (pop_ok) begin
                sp    <= sp - PW'(1);
                count <= count - CW'(1);
            end
            if (ovf_hit) begin
                overflow <= 1'b1;
            end
            if (udf_hit) begin
                underflow <= 1'b1;
            end
        end
    end

    ret_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_dat  (din),
        .rd_addr (top_idx),
        .rd_dat  (rd_dat)
    );

    assign dout = empty ? '0 : rd_dat;

endmodule

// File: tb/tb_ret_stack.sv
// Directed bench for ret_stack at WIDTH=10, DEPTH=8; follows RET_STACK_WRAP_EN if defined.
module tb_ret_stack;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic       pop;
    logic [9:0] din;
    logic [9:0] dout;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ret_stack #(.WIDTH(10), .DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .din       (din),
        .dout      (dout),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; push = 1'b0; pop = 1'b0; din = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic push_val(input logic [9:0] v);
        push = 1'b1; din = v;
        step();
        push = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dout !== 10'h000) begin failures++; $display("FAIL reset_dout got=%h exp=000", dout); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
    endtask

    task automatic test_lifo();
        logic [9:0] exp_pop [3];
        exp_pop = '{10'h103, 10'h102, 10'h101};
        do_reset();
        push_val(10'h101);
        push_val(10'h102);
        push_val(10'h103);
        checks++; if (count !== 4'd3) begin failures++; $display("FAIL lifo_count got=%0d exp=3", count); end
        checks++; if (dout !== 10'h103) begin failures++; $display("FAIL lifo_top got=%h exp=103", dout); end
        for (int i = 0; i < 3; i++) begin
            pop = 1'b1;
            #1;
            checks++; if (dout !== exp_pop[i]) begin failures++; $display("FAIL lifo_pop%0d got=%h exp=%h", i, dout, exp_pop[i]); end
            step();
            pop = 1'b0;
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL lifo_empty got=%b exp=1", empty); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL lifo_no_underflow got=%b exp=0", underflow); end
    endtask

    task automatic test_underflow();
        do_reset();
        pop = 1'b1;
        step();
        pop = 1'b0;
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL udf_set got=%b exp=1", underflow); end
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL udf_count got=%0d exp=0", count); end
        checks++; if (dout !== 10'h000) begin failures++; $display("FAIL udf_dout got=%h exp=000", dout); end
        step();
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL udf_sticky got=%b exp=1", underflow); end
        push_val(10'h005);
        checks++; if (dout !== 10'h005) begin failures++; $display("FAIL udf_push_dout got=%h exp=005", dout); end
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL udf_push_count got=%0d exp=1", count); end
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL udf_after_push got=%b exp=1", underflow); end
    endtask

    task automatic test_push_pop_empty();
        do_reset();
        push = 1'b1; pop = 1'b1; din = 10'h033;
        step();
        push = 1'b0; pop = 1'b0;
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL pp_empty_count got=%0d exp=1", count); end
        checks++; if (dout !== 10'h033) begin failures++; $display("FAIL pp_empty_dout got=%h exp=033", dout); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL pp_empty_underflow got=%b exp=0", underflow); end
    endtask

    task automatic test_overflow();
        logic [9:0] top_exp;
`ifdef RET_STACK_WRAP_EN
        top_exp = 10'h009;
`else
        top_exp = 10'h008;
`endif
        do_reset();
        for (int i = 1; i <= 9; i++) push_val(10'(i));
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", full); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", count); end
        checks++; if (dout !== top_exp) begin failures++; $display("FAIL ovf_top got=%h exp=%h", dout, top_exp); end
        for (int i = 0; i < 8; i++) begin
            pop = 1'b1;
            #1;
            checks++; if (dout !== top_exp - 10'(i)) begin failures++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, dout, top_exp - 10'(i)); end
            step();
            pop = 1'b0;
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ovf_drained got=%b exp=1", empty); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_replace();
        do_reset();
        push_val(10'h011);
        push_val(10'h0A0);
        push = 1'b1; pop = 1'b1; din = 10'h0B0;
        #1;
        checks++; if (dout !== 10'h0A0) begin failures++; $display("FAIL repl_old_top got=%h exp=0a0", dout); end
        step();
        push = 1'b0; pop = 1'b0;
        checks++; if (dout !== 10'h0B0) begin failures++; $display("FAIL repl_new_top got=%h exp=0b0", dout); end
        checks++; if (count !== 4'd2) begin failures++; $display("FAIL repl_count got=%0d exp=2", count); end
        pop = 1'b1;
        step();
        pop = 1'b0;
        checks++; if (dout !== 10'h011) begin failures++; $display("FAIL repl_below got=%h exp=011", dout); end
    endtask

    task automatic test_reset_priority();
        do_reset();
        for (int i = 1; i <= 9; i++) push_val(10'h040 + 10'(i));
        pop = 1'b1;
        for (int i = 0; i < 4; i++) step();
        pop = 1'b0;
        checks++; if (count !== 4'd4) begin failures++; $display("FAIL rstp_pre_count got=%0d exp=4", count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL rstp_pre_ovf got=%b exp=1", overflow); end
        reset = 1'b1; push = 1'b1; din = 10'h077;
        step();
        reset = 1'b0; push = 1'b0;
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL rstp_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rstp_empty got=%b exp=1", empty); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rstp_ovf got=%b exp=0", overflow); end
        checks++; if (dout !== 10'h000) begin failures++; $display("FAIL rstp_dout got=%h exp=000", dout); end
        step();
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL rstp_push_lost got=%0d exp=0", count); end
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; din = '0;
        step();
        test_reset();
        test_lifo();
        test_underflow();
        test_push_pop_empty();
        test_overflow();
        test_replace();
        test_reset_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
